// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the I2C register sequencer and byte master
// Command codes match the byte-level master; step_e lists the transaction steps.
package i2c_pkg;

  typedef enum logic [2:0] {
    START_CMD   = 3'd0,
    WR_CMD      = 3'd1,
    RD_CMD      = 3'd2,
    STOP_CMD    = 3'd3,
    RESTART_CMD = 3'd4
  } i2c_cmd_e;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_ADDR_NACK = 2'd1,
    ERR_DATA_NACK = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } rsp_err_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDRW,
    S_REG,
    S_WDATA,
    S_RESTART,
    S_ADDRR,
    S_RDATA,
    S_STOP,
    S_DONE
  } step_e;

  // bit0 set tells the master to NACK the single read byte
  localparam logic [7:0] RD_NACK_DIN = 8'h01;

  function automatic i2c_cmd_e step_cmd(input step_e s);
    case (s)
      S_START:   return START_CMD;
      S_RESTART: return RESTART_CMD;
      S_RDATA:   return RD_CMD;
      S_STOP:    return STOP_CMD;
      default:   return WR_CMD;
    endcase
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// rtl/i2c_reg_sequencer_if.sv - request/response and byte-master signals of the sequencer
// master = sequencer view, slave = requester plus byte-master view.
interface i2c_reg_sequencer_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;

  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;

  logic [2:0] i2c_cmd;
  logic [7:0] i2c_din;
  logic       i2c_wr;
  logic       i2c_ready;
  logic       i2c_done_tick;
  logic       i2c_ack;
  logic [7:0] i2c_dout;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output i2c_cmd, i2c_din, i2c_wr,
    input  i2c_ready, i2c_done_tick, i2c_ack, i2c_dout
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  i2c_cmd, i2c_din, i2c_wr,
    output i2c_ready, i2c_done_tick, i2c_ack, i2c_dout
  );

endinterface

// File: rtl/i2c_cmd_issuer.sv
// rtl/i2c_cmd_issuer.sv - issues one byte-master command and waits for it to finish
// ISSUE -> BUSY -> WAIT handshake on i2c_ready, guarded by a saturating watchdog.
module i2c_cmd_issuer
  import i2c_pkg::*;
#(
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  i2c_cmd_e   cmd_i,
  input  logic [7:0] din_i,
  output logic       done_o,
  output logic       ack_o,
  output logic [7:0] dout_o,
  output logic       timeout_o,
  output logic [2:0] i2c_cmd_o,
  output logic [7:0] i2c_din_o,
  output logic       i2c_wr_o,
  input  logic       i2c_ready_i,
  input  logic       i2c_done_tick_i,
  input  logic       i2c_ack_i,
  input  logic [7:0] i2c_dout_i
);

  typedef enum logic [1:0] {IS_IDLE, IS_ISSUE, IS_BUSY, IS_WAIT} iss_state_e;

  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_MAX - TIMEOUT_W'(1);

  iss_state_e           state_q;
  i2c_cmd_e             cmd_q;
  logic [7:0]           din_q;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic                 done_q;
  logic                 timeout_q;
  logic                 ack_q;
  logic [7:0]           dout_q;
  logic                 active;
  logic                 finishing;

  assign active    = (state_q != IS_IDLE);
  // Gated by the live ready so a strobe can never land while the master is busy.
  assign i2c_wr_o  = (state_q == IS_ISSUE) && i2c_ready_i;
  assign finishing = i2c_wr_o || ((state_q == IS_WAIT) && i2c_ready_i);

  assign i2c_cmd_o = cmd_q;
  assign i2c_din_o = din_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign ack_o     = ack_q;
  assign dout_o    = dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IS_IDLE;
      cmd_q     <= START_CMD;
      din_q     <= 8'h00;
      wdog_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (active && (wdog_q != '1)) begin
        wdog_q <= wdog_q + TIMEOUT_W'(1);
      end
      case (state_q)
        IS_IDLE: begin
          if (go_i) begin
            cmd_q   <= cmd_i;
            din_q   <= din_i;
            ack_q   <= 1'b0;
            wdog_q  <= '0;
            state_q <= IS_ISSUE;
          end
        end
        IS_ISSUE: begin
          if (i2c_ready_i) begin
            state_q <= IS_BUSY;
          end
        end
        IS_BUSY: begin
          if (!i2c_ready_i) begin
            state_q <= IS_WAIT;
          end
        end
        IS_WAIT: begin
          if (i2c_done_tick_i && ((cmd_q == WR_CMD) || (cmd_q == RD_CMD))) begin
            ack_q  <= i2c_ack_i;
            dout_q <= i2c_dout_i;
          end
          if (i2c_ready_i) begin
            done_q  <= 1'b1;
            state_q <= IS_IDLE;
          end
        end
        default: state_q <= IS_IDLE;
      endcase
      if (active && !finishing && (wdog_q >= WDOG_LAST)) begin
        timeout_q <= 1'b1;
        state_q   <= IS_IDLE;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - register read/write transaction sequencer for a byte-level I2C master
// Step FSM: START, address, register, then write byte or RESTART/read, then STOP.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
  input logic                 clk,
  input logic                 reset,
  i2c_reg_sequencer_if.master bus
);

  step_e      step_q;
  logic       launched_q;
  logic       go_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rd_byte_q;
  rsp_err_e   err_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  rsp_err_e   rsp_err_q;

  i2c_cmd_e   step_cmd_w;
  logic [7:0] step_din;
  logic       iss_done;
  logic       iss_ack;
  logic       iss_timeout;
  logic [7:0] iss_dout;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign step_cmd_w = step_cmd(step_q);

  always_comb begin
    step_din = 8'h00;
    case (step_q)
      S_ADDRW: step_din = {dev_q, 1'b0};
      S_REG:   step_din = reg_q;
      S_WDATA: step_din = wdata_q;
      S_ADDRR: step_din = {dev_q, 1'b1};
      S_RDATA: step_din = RD_NACK_DIN;
      default: step_din = 8'h00;
    endcase
  end

  i2c_cmd_issuer #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_MAX (TIMEOUT_MAX)
  ) u_issuer (
    .clk             (clk),
    .reset           (reset),
    .go_i            (go_q),
    .cmd_i           (step_cmd_w),
    .din_i           (step_din),
    .done_o          (iss_done),
    .ack_o           (iss_ack),
    .dout_o          (iss_dout),
    .timeout_o       (iss_timeout),
    .i2c_cmd_o       (bus.i2c_cmd),
    .i2c_din_o       (bus.i2c_din),
    .i2c_wr_o        (bus.i2c_wr),
    .i2c_ready_i     (bus.i2c_ready),
    .i2c_done_tick_i (bus.i2c_done_tick),
    .i2c_ack_i       (bus.i2c_ack),
    .i2c_dout_i      (bus.i2c_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q      <= S_IDLE;
      launched_q  <= 1'b0;
      go_q        <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rd_byte_q   <= 8'h00;
      err_q       <= ERR_OK;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= ERR_OK;
    end else begin
      go_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (step_q)
        S_IDLE: begin
          // Ready comes back one cycle after rsp_valid, leaving a gap before the next accept.
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            rw_q        <= bus.req_rw;
            dev_q       <= bus.req_dev;
            reg_q       <= bus.req_reg;
            wdata_q     <= bus.req_wdata;
            err_q       <= ERR_OK;
            launched_q  <= 1'b0;
            req_ready_q <= 1'b0;
            step_q      <= S_START;
          end
        end
        S_DONE: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          if ((err_q == ERR_OK) && rw_q) begin
            rsp_rdata_q <= rd_byte_q;
          end
          step_q <= S_IDLE;
        end
        default: begin
          if (!launched_q) begin
            go_q       <= 1'b1;
            launched_q <= 1'b1;
          end else if (iss_timeout) begin
            // Master presumed hung: report without attempting STOP.
            err_q      <= ERR_TIMEOUT;
            launched_q <= 1'b0;
            step_q     <= S_DONE;
          end else if (iss_done) begin
            launched_q <= 1'b0;
            case (step_q)
              S_START: step_q <= S_ADDRW;
              S_ADDRW: begin
                if (iss_ack) begin
                  err_q  <= ERR_ADDR_NACK;
                  step_q <= S_STOP;
                end else begin
                  step_q <= S_REG;
                end
              end
              S_REG: begin
                if (iss_ack) begin
                  err_q  <= ERR_DATA_NACK;
                  step_q <= S_STOP;
                end else begin
                  step_q <= rw_q ? S_RESTART : S_WDATA;
                end
              end
              S_WDATA: begin
                if (iss_ack) begin
                  err_q <= ERR_DATA_NACK;
                end
                step_q <= S_STOP;
              end
              S_RESTART: step_q <= S_ADDRR;
              S_ADDRR: begin
                if (iss_ack) begin
                  err_q  <= ERR_ADDR_NACK;
                  step_q <= S_STOP;
                end else begin
                  step_q <= S_RDATA;
                end
              end
              S_RDATA: begin
                rd_byte_q <= iss_dout;
                step_q    <= S_STOP;
              end
              default: step_q <= S_DONE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - self-checking bench for i2c_reg_sequencer
// Byte-master/slave model with command and response scoreboards driven from a vector table.
module tb_i2c_reg_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_reg_sequencer_if bus();

  i2c_reg_sequencer #(
    .TIMEOUT_W   (20),
    .TIMEOUT_MAX (20'd100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] regad;
    logic [7:0] wdata;
    int         nack_idx;
    logic [7:0] rd_byte;
    logic [1:0] exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t        vecs[8];
  logic [10:0] exp_cmd_q[$];
  logic [9:0]  exp_rsp_q[$];

  logic       hang_en     = 1'b0;
  logic       hung        = 1'b0;
  logic       pend        = 1'b0;
  logic [2:0] pcmd        = 3'd0;
  int         busy        = 0;
  int         wr_idx      = 0;
  int         nack_idx_cur = 0;
  logic [7:0] rd_byte_cur = 8'h00;
  int         cmd_cnt     = 0;
  int         start_cyc   = 0;
  int         rsp_cnt     = 0;
  int         rsp_cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin : master_model
    logic [10:0] e;
    bus.i2c_ready     = 1'b1;
    bus.i2c_done_tick = 1'b0;
    bus.i2c_ack       = 1'b0;
    bus.i2c_dout      = 8'h00;
    forever begin
      @(negedge clk);
      bus.i2c_done_tick = 1'b0;
      if (reset) begin
        pend = 1'b0;
        busy = 0;
        hung = 1'b0;
        bus.i2c_ready = 1'b1;
      end else if (pend) begin
        pend = 1'b0;
        bus.i2c_ready = 1'b0;
        if (hang_en && (pcmd == 3'd0)) hung = 1'b1;
        else busy = 3;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (pcmd == 3'd1) begin
            wr_idx++;
            bus.i2c_ack       = (wr_idx == nack_idx_cur);
            bus.i2c_dout      = 8'($urandom);
            bus.i2c_done_tick = 1'b1;
          end else if (pcmd == 3'd2) begin
            bus.i2c_ack       = 1'b1;
            bus.i2c_dout      = rd_byte_cur;
            bus.i2c_done_tick = 1'b1;
          end
          bus.i2c_ready = 1'b1;
        end
      end else if (hung) begin
        if (bus.i2c_wr) begin
          checks++;
          errors++;
          $display("FAIL wr_while_not_ready: i2c_wr=1 with i2c_ready=0, required 0");
        end
      end else begin
        bus.i2c_ready = 1'b1;
        if (bus.i2c_wr) begin
          pcmd = bus.i2c_cmd;
          pend = 1'b1;
          cmd_cnt++;
          if (pcmd == 3'd0) begin
            wr_idx    = 0;
            start_cyc = cyc;
          end
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got cmd %0d din %0h, required none", bus.i2c_cmd, bus.i2c_din);
          end else begin
            e = exp_cmd_q.pop_front();
            if ((e[10:8] == 3'd1) || (e[10:8] == 3'd2))
              check("cmd_byte", {21'd0, bus.i2c_cmd, bus.i2c_din}, {21'd0, e});
            else
              check("cmd", {29'd0, bus.i2c_cmd}, {29'd0, e[10:8]});
          end
        end
      end
    end
  end

  initial begin : rsp_monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got err %0d rdata %0h, required no response", bus.rsp_err, bus.rsp_rdata);
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp_err", {30'd0, bus.rsp_err}, {30'd0, e[9:8]});
          check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic push_cmds(input vec_t v);
    exp_cmd_q.push_back({3'd0, 8'h00});
    exp_cmd_q.push_back({3'd1, v.dev, 1'b0});
    if (v.nack_idx != 1) begin
      exp_cmd_q.push_back({3'd1, v.regad});
      if (v.nack_idx != 2) begin
        if (!v.rw) begin
          exp_cmd_q.push_back({3'd1, v.wdata});
        end else begin
          exp_cmd_q.push_back({3'd4, 8'h00});
          exp_cmd_q.push_back({3'd1, v.dev, 1'b1});
          if (v.nack_idx != 3) exp_cmd_q.push_back({3'd2, 8'h01});
        end
      end
    end
    exp_cmd_q.push_back({3'd3, 8'h00});
  endtask

  task automatic issue_req(input vec_t v);
    int n = 0;
    nack_idx_cur = v.nack_idx;
    rd_byte_cur  = v.rd_byte;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = v.rw;
    bus.req_dev   = v.dev;
    bus.req_reg   = v.regad;
    bus.req_wdata = v.wdata;
    while (!bus.req_ready && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
  endtask

  task automatic wait_rsp(input int base, input int limit);
    int n = 0;
    while ((rsp_cnt == base) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got no rsp_valid in %0d cycles, required one", limit);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    push_cmds(v);
    exp_rsp_q.push_back({v.exp_err, v.exp_rdata});
    base = rsp_cnt;
    issue_req(v);
    wait_rsp(base, 400);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    vec_t v;
    int   base;
    int   n;
    int   delta;

    vecs[0] = '{rw:1'b0, dev:7'h50, regad:8'h10, wdata:8'hA5, nack_idx:0, rd_byte:8'h00, exp_err:2'd0, exp_rdata:8'h00};
    vecs[1] = '{rw:1'b1, dev:7'h50, regad:8'h20, wdata:8'h00, nack_idx:0, rd_byte:8'h3C, exp_err:2'd0, exp_rdata:8'h3C};
    vecs[2] = '{rw:1'b0, dev:7'h12, regad:8'h10, wdata:8'h55, nack_idx:1, rd_byte:8'h00, exp_err:2'd1, exp_rdata:8'h3C};
    vecs[3] = '{rw:1'b1, dev:7'h50, regad:8'h33, wdata:8'h00, nack_idx:2, rd_byte:8'h99, exp_err:2'd2, exp_rdata:8'h3C};
    vecs[4] = '{rw:1'b0, dev:7'h50, regad:8'h44, wdata:8'h5A, nack_idx:3, rd_byte:8'h00, exp_err:2'd2, exp_rdata:8'h3C};
    vecs[5] = '{rw:1'b1, dev:7'h2B, regad:8'h7F, wdata:8'h00, nack_idx:3, rd_byte:8'h77, exp_err:2'd1, exp_rdata:8'h3C};
    vecs[6] = '{rw:1'b1, dev:7'h7F, regad:8'hFF, wdata:8'h00, nack_idx:0, rd_byte:8'hC3, exp_err:2'd0, exp_rdata:8'hC3};
    vecs[7] = '{rw:1'b0, dev:7'h00, regad:8'h00, wdata:8'hFF, nack_idx:0, rd_byte:8'h00, exp_err:2'd0, exp_rdata:8'hC3};

    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_dev   = 7'h00;
    bus.req_reg   = 8'h00;
    bus.req_wdata = 8'h00;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    check("rst_rsp_err", {30'd0, bus.rsp_err}, 32'd0);
    check("rst_i2c_wr", {31'd0, bus.i2c_wr}, 32'd0);
    check("rst_i2c_cmd", {29'd0, bus.i2c_cmd}, 32'd0);
    check("rst_i2c_din", {24'd0, bus.i2c_din}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Master stalls after START: watchdog must abandon with no STOP.
    hang_en = 1'b1;
    v = vecs[0];
    exp_cmd_q.push_back({3'd0, 8'h00});
    exp_rsp_q.push_back({2'd3, 8'hC3});
    base = rsp_cnt;
    issue_req(v);
    wait_rsp(base, 300);
    delta = rsp_cyc - start_cyc;
    checks++;
    if ((delta < 98) || (delta > 106)) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles from START strobe, required 98..106", delta);
    end
    hang_en = 1'b0;
    hung    = 1'b0;
    repeat (20) @(negedge clk);
    check("timeout_no_stop", exp_cmd_q.size(), 32'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while the register byte is in flight.
    v = '{rw:1'b0, dev:7'h50, regad:8'h66, wdata:8'h77, nack_idx:0, rd_byte:8'h00, exp_err:2'd0, exp_rdata:8'h00};
    exp_cmd_q.push_back({3'd0, 8'h00});
    exp_cmd_q.push_back({3'd1, 8'hA0});
    exp_cmd_q.push_back({3'd1, 8'h66});
    base = cmd_cnt;
    issue_req(v);
    n = 0;
    while ((cmd_cnt < base + 3) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check("reg_byte_reached", cmd_cnt - base, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrst_i2c_wr", {31'd0, bus.i2c_wr}, 32'd0);
    check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);

    v = vecs[0];
    run_vec(v);

    check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
    check("rsp_queue_drained", exp_rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
